// File: rtl/timer_array_pkg.sv
// Register map constants and channel offset helpers for timer_array.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package timer_array_pkg;

   localparam int OFF_CLOCK   = 0;
   localparam int OFF_PRE     = 1;
   localparam int OFF_FLAGS   = 2;
   localparam int OFF_IE      = 3;
   localparam int OFF_ARE     = 4;
   localparam int OFF_CH_BASE = 8;

   // Each channel occupies two consecutive words: CNT then RLD.
   function automatic int ch_cnt_off(input int i);
      return OFF_CH_BASE + 2 * i;
   endfunction

   function automatic int ch_rld_off(input int i);
      return OFF_CH_BASE + 2 * i + 1;
   endfunction

endpackage

// File: rtl/timer_array_if.sv
// CPU data-bus view of the timer peripheral: word address, write data, strobes, read data, irq.
// Latency: reads are combinational, writes take effect on the next rising clk edge.
// Backpressure: none; the slave accepts every access in the cycle it is presented.
interface timer_array_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] addr;
   logic [WIDTH-1:0] din;
   logic             wen;
   logic             cs;
   logic [WIDTH-1:0] dout;
   logic             irq;

   modport master (output addr, output din, output wen, output cs, input dout, input irq);
   modport slave  (input addr, input din, input wen, input cs, output dout, output irq);
endinterface

// File: rtl/timer_channel.sv
// One down-counter channel: CNT/RLD registers, countdown, optional auto-reload, expiry pulse.
// Latency: CNT updates on the clk edge after a tick or write; o_expire is combinational in the tick cycle.
// Backpressure: none; a CNT write always beats a same-cycle tick.
// Ports: clk/reset; i_tick prescaler tick; i_wr_cnt/i_wr_rld write strobes with i_din;
//        i_are auto-reload enable; o_cnt/o_rld register values; o_expire one-cycle expiry pulse.
module timer_channel #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_tick,
   input  logic             i_wr_cnt,
   input  logic             i_wr_rld,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_are,
   output logic [WIDTH-1:0] o_cnt,
   output logic [WIDTH-1:0] o_rld,
   output logic             o_expire
);
   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_rld;
   logic             w_at_one;

   assign w_at_one = (r_cnt == WIDTH'(1));
   // A software load in the same cycle suppresses the expiry.
   assign o_expire = i_tick & w_at_one & ~i_wr_cnt;
   assign o_cnt    = r_cnt;
   assign o_rld    = r_rld;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
         r_rld <= '0;
      end else begin
         if (i_wr_rld)
            r_rld <= i_din;
         if (i_wr_cnt)
            r_cnt <= i_din;
         else if (o_expire)
            r_cnt <= i_are ? r_rld : '0;
         else if (i_tick && (r_cnt > WIDTH'(1)))
            r_cnt <= r_cnt - WIDTH'(1);
         // CNT==0 holds: the channel never underflows.
      end
   end
endmodule

// File: rtl/timer_array.sv
// Memory-mapped timer: shared prescaler, free-running CLOCK, NCH down-counter channels, OR-ed irq.
// Latency: combinational reads; writes and tick effects land on the next clk edge; irq follows FLAGS directly.
// Backpressure: none; every bus access completes in its own cycle.
// Ports: clk; reset (async, active-high); bus (slave modport: addr, din, wen, cs in; dout, irq out).
module timer_array
   import timer_array_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NCH       = 4,
   parameter int ADDR_BITS = 6
) (
   input  logic          clk,
   input  logic          reset,
   timer_array_if.slave  bus
);
   logic [WIDTH-1:0]     r_clock;
   logic [WIDTH-1:0]     r_pre;
   logic [WIDTH-1:0]     r_precnt;
   logic [NCH-1:0]       r_flags;
   logic [NCH-1:0]       r_ie;
   logic [NCH-1:0]       r_are;

   logic [ADDR_BITS-1:0] w_off;
   logic                 w_wr;
   logic                 w_wr_clock;
   logic                 w_wr_pre;
   logic                 w_wr_flags;
   logic                 w_wr_ie;
   logic                 w_wr_are;
   logic                 w_pre_en;
   logic                 w_tick;
   logic [NCH-1:0]       w_expire;
   logic [NCH-1:0]       w_clr;
   logic [WIDTH-1:0]     w_cnt [NCH];
   logic [WIDTH-1:0]     w_rld [NCH];
   logic [WIDTH-1:0]     w_dout;
   logic                 w_unused_addr;

   assign w_off         = bus.addr[ADDR_BITS-1:0];
   assign w_unused_addr = ^bus.addr[WIDTH-1:ADDR_BITS];
   assign w_wr          = bus.cs & bus.wen;
   assign w_wr_clock    = w_wr & (w_off == ADDR_BITS'(OFF_CLOCK));
   assign w_wr_pre      = w_wr & (w_off == ADDR_BITS'(OFF_PRE));
   assign w_wr_flags    = w_wr & (w_off == ADDR_BITS'(OFF_FLAGS));
   assign w_wr_ie       = w_wr & (w_off == ADDR_BITS'(OFF_IE));
   assign w_wr_are      = w_wr & (w_off == ADDR_BITS'(OFF_ARE));

   // PRE=0 disables the prescaler entirely, freezing every counter.
   assign w_pre_en = |r_pre;
   assign w_tick   = w_pre_en & (r_precnt == r_pre);
   assign w_clr    = w_wr_flags ? bus.din[NCH-1:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clock  <= '0;
         r_pre    <= '0;
         r_precnt <= '0;
         r_flags  <= '0;
         r_ie     <= '0;
         r_are    <= '0;
      end else begin
         if (w_wr_pre) begin
            r_pre    <= bus.din;
            r_precnt <= '0;
         end else if (w_tick) begin
            r_precnt <= '0;
         end else if (w_pre_en) begin
            r_precnt <= r_precnt + WIDTH'(1);
         end

         if (w_wr_clock)
            r_clock <= bus.din;
         else if (w_tick)
            r_clock <= r_clock + WIDTH'(1);

         if (w_wr_ie)
            r_ie <= bus.din[NCH-1:0];
         if (w_wr_are)
            r_are <= bus.din[NCH-1:0];

         // Set after clear so a same-cycle expiry is never lost.
         r_flags <= (r_flags & ~w_clr) | w_expire;
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      timer_channel #(.WIDTH(WIDTH)) u_ch (
         .clk      (clk),
         .reset    (reset),
         .i_tick   (w_tick),
         .i_wr_cnt (w_wr & (w_off == ADDR_BITS'(ch_cnt_off(g)))),
         .i_wr_rld (w_wr & (w_off == ADDR_BITS'(ch_rld_off(g)))),
         .i_din    (bus.din),
         .i_are    (r_are[g]),
         .o_cnt    (w_cnt[g]),
         .o_rld    (w_rld[g]),
         .o_expire (w_expire[g])
      );
   end

   always_comb begin
      w_dout = '0;
      if (bus.cs) begin
         if (w_off == ADDR_BITS'(OFF_CLOCK))      w_dout = r_clock;
         else if (w_off == ADDR_BITS'(OFF_PRE))   w_dout = r_pre;
         else if (w_off == ADDR_BITS'(OFF_FLAGS)) w_dout = WIDTH'(r_flags);
         else if (w_off == ADDR_BITS'(OFF_IE))    w_dout = WIDTH'(r_ie);
         else if (w_off == ADDR_BITS'(OFF_ARE))   w_dout = WIDTH'(r_are);
         for (int i = 0; i < NCH; i++) begin
            if (w_off == ADDR_BITS'(ch_cnt_off(i))) w_dout = w_cnt[i];
            if (w_off == ADDR_BITS'(ch_rld_off(i))) w_dout = w_rld[i];
         end
      end
   end

   assign bus.dout = w_dout;
   assign bus.irq  = |(r_flags & r_ie);
endmodule

// File: doc/timer_array.md
Name: timer_array

Overview:
Parametrised successor of the memory-mapped clock/timer peripheral, sitting on the CPU data bus beside other I/O slaves.
- A shared prescaler generates a periodic tick.
- The tick advances a free-running CLOCK counter and NCH independent down-counter channels.
- Each channel supports one-shot or auto-reload mode, a sticky expiry flag and an interrupt enable.
- Flags are OR-reduced onto a single irq line.

Parameters:
WIDTH, 32, data and counter width in bits.
NCH, 4, number of down-counter channels; 1 <= NCH <= WIDTH.
ADDR_BITS, 6, decoded address bits; 8+2*NCH <= 2**ADDR_BITS.

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high; clears all state.
addr  in  WIDTH  word address; only addr[ADDR_BITS-1:0] is decoded.
din  in  WIDTH  write data.
wen  in  1  write enable, qualified by cs.
cs  in  1  chip select.
dout  out  WIDTH  combinational read data; 0 when cs=0 or address unmapped.
irq  out  1  interrupt request, level, = |(FLAGS & IE).

Behaviour:
- Register map (word offsets):
  - 0 CLOCK (rw)
  - 1 PRE (rw)
  - 2 FLAGS (r; write-1-to-clear)
  - 3 IE (rw)
  - 4 ARE, auto-reload enable bitmask (rw)
  - 5-7 reserved: read 0, writes ignored
  - 8+2i CNT[i] (rw)
  - 9+2i RLD[i] (rw), for i = 0..NCH-1
- FLAGS, IE and ARE use bits [NCH-1:0]; upper bits read 0.
- Write strobe: wr_k = cs & wen & (addr == k). Reads have zero latency (combinational mux).
- Reset values: every register, the prescaler count, dout and irq are 0.
- Prescaler:
  - en = |PRE.
  - precnt counts 0..PRE; tick = en & (precnt == PRE).
  - precnt clears on reset, on tick, or on a PRE write; otherwise it increments while en=1.
  - Tick period is PRE+1 clocks. PRE=0 means no ticks and all counters frozen.
- CLOCK: wr_0 loads din. Otherwise CLOCK increments by 1 on tick and wraps 2^WIDTH-1 -> 0. A write beats a tick in the same cycle.
- Channel i, priority order:
  - wr CNT[i]: load din; no flag action.
  - tick & CNT==1: set FLAGS[i]; CNT <= ARE[i] ? RLD[i] : 0.
  - tick & CNT>1: CNT <= CNT-1.
  - CNT==0: hold; never underflows, no flag.
- Auto-reload with RLD=0 reloads 0, so the channel stops after one expiry.
- RLD is only a holding register; writing it never affects the current count.
- FLAGS:
  - Write at offset 2 clears bits where din=1.
  - A set in the same cycle as its clear: set wins (the expiry is not lost).
- irq: combinational from registered FLAGS and IE, with no extra latency beyond the flag register. Clears the cycle after the W1C write.
- Asynchronous reset mid-count: everything returns to 0 immediately. irq drops without waiting for clk.

Decomposition:
- Package timer_array_pkg holds:
  - Register offset constants: OFF_CLOCK=0, OFF_PRE=1, OFF_FLAGS=2, OFF_IE=3, OFF_ARE=4, OFF_CH_BASE=8.
  - A function ch_cnt_off(i) / ch_rld_off(i).
- Sub-module timer_channel, instantiated NCH times via generate. It contains:
  - CNT and RLD registers and the countdown/reload logic.
  - A one-cycle expire pulse output.
- The top level owns the prescaler, CLOCK, FLAGS/IE/ARE, the read mux and irq.

Test Plan:
1. Reset then PRE=3, CLOCK=0 -> CLOCK reads 1 after 4 clocks and 5 after 20 clocks. PRE=0 write -> CLOCK holds at its current value.
2. PRE=1, CNT0=3, ARE=0, IE=1 -> FLAGS[0]=1 and irq=1 exactly 6 clocks after the PRE write; CNT0 stays 0 afterwards. Write FLAGS=1 -> irq=0 next cycle.
3. PRE=0 then ARE[1]=1, RLD1=2, CNT1=2, then PRE=1 -> FLAGS[1] sets every 4 clocks. CNT1 sequence per tick is 2,1,2,1... Clear FLAGS[1] on an expiry cycle -> FLAGS[1] remains 1.
4. Write CNT2=5 in the same cycle as a tick, and CLOCK=100 in the same cycle as a tick -> CNT2 reads 5 and CLOCK reads 100 afterwards.
5. NCH=4, reads of offsets 5, 6, 7 and 16, and any read with cs=0 -> dout=0. FLAGS[1] set with IE=0 -> irq=0; then IE=2 -> irq=1.
6. Assert reset asynchronously between clock edges while counters run and irq=1 -> irq and all registers read 0 immediately; after reset release with PRE=0, no ticks occur.
